// File: rtl/hpdcache_mem_req_id_alloc.sv
// Memory request ID allocator: round-robin arbitration of N requesters onto one registered
// request slot, tagging each request with a free transaction ID and recording its owner port.
module hpdcache_mem_req_id_alloc #(
    parameter int N         = 4,
    parameter int ID_WIDTH  = 2,
    parameter int REQ_WIDTH = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [N-1:0]                       req_valid_i,
    output logic [N-1:0]                       req_ready_o,
    input  logic [N*REQ_WIDTH-1:0]             req_i,
    output logic                               mem_req_valid_o,
    input  logic                               mem_req_ready_i,
    output logic [REQ_WIDTH-1:0]               mem_req_o,
    output logic [ID_WIDTH-1:0]                mem_req_id_o,
    input  logic                               rel_valid_i,
    input  logic [ID_WIDTH-1:0]                rel_id_i,
    output logic [(1<<ID_WIDTH)*ID_WIDTH-1:0]  mem_resp_rt_o,
    output logic [ID_WIDTH:0]                  ids_free_o,
    output logic                               rel_err_o
);
    localparam int RT_DEPTH = 1 << ID_WIDTH;
    localparam int PW       = (N > 1) ? $clog2(N) : 1;
    localparam int CW       = ID_WIDTH + 1;

    generate
        if ($clog2(N) > ID_WIDTH) begin : g_bad_cfg
            $error("hpdcache_mem_req_id_alloc: ID_WIDTH too small to hold a port index");
        end
    endgenerate

    logic [REQ_WIDTH-1:0] req_arr [N];
    logic [ID_WIDTH-1:0]  rt_reg [RT_DEPTH];
    logic [RT_DEPTH-1:0]  busy_reg;
    logic [PW-1:0]        rr_ptr_reg;
    logic                 valid_reg;
    logic [REQ_WIDTH-1:0] req_reg;
    logic [ID_WIDTH-1:0]  id_reg;
    logic [CW-1:0]        ids_free_reg;
    logic                 rel_err_reg;

    logic                 grant_found;
    logic [PW-1:0]        grant_idx;
    logic [PW:0]          cand_sum;
    logic                 free_found;
    logic [ID_WIDTH-1:0]  free_idx;
    logic                 grant;
    logic                 rel_ok;

    for (genvar gi = 0; gi < N; gi++) begin : g_req
        assign req_arr[gi] = req_i[gi*REQ_WIDTH +: REQ_WIDTH];
    end

    for (genvar gi = 0; gi < RT_DEPTH; gi++) begin : g_rt
        assign mem_resp_rt_o[gi*ID_WIDTH +: ID_WIDTH] = rt_reg[gi];
    end

    // Round-robin: first valid port at or after rr_ptr, wrapping at N-1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_sum    = '0;
        for (int i = 0; i < N; i++) begin
            cand_sum = {1'b0, rr_ptr_reg} + (PW+1)'(i);
            if (cand_sum >= (PW+1)'(N)) begin
                cand_sum = cand_sum - (PW+1)'(N);
            end
            if (!grant_found && req_valid_i[cand_sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand_sum[PW-1:0];
            end
        end
    end

    // Lowest-index free ID, judged on registered busy bits only.
    always_comb begin
        free_found = |(~busy_reg);
        free_idx   = '0;
        for (int k = RT_DEPTH - 1; k >= 0; k--) begin
            if (!busy_reg[k]) begin
                free_idx = ID_WIDTH'(k);
            end
        end
    end

    assign grant  = (!valid_reg || mem_req_ready_i) && free_found && grant_found;
    assign rel_ok = rel_valid_i && busy_reg[rel_id_i];

    always_comb begin
        req_ready_o = '0;
        if (grant) begin
            req_ready_o[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_reg     <= '0;
            rr_ptr_reg   <= '0;
            valid_reg    <= 1'b0;
            req_reg      <= '0;
            id_reg       <= '0;
            ids_free_reg <= CW'(RT_DEPTH);
            rel_err_reg  <= 1'b0;
            for (int k = 0; k < RT_DEPTH; k++) begin
                rt_reg[k] <= '0;
            end
        end else begin
            if (rel_valid_i) begin
                if (busy_reg[rel_id_i]) begin
                    busy_reg[rel_id_i] <= 1'b0;
                end else begin
                    rel_err_reg <= 1'b1;
                end
            end
            // The allocated ID is free, so it never collides with a legal release.
            if (grant) begin
                valid_reg          <= 1'b1;
                req_reg            <= req_arr[grant_idx];
                id_reg             <= free_idx;
                busy_reg[free_idx] <= 1'b1;
                rt_reg[free_idx]   <= ID_WIDTH'(grant_idx);
                rr_ptr_reg         <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + PW'(1);
            end else if (mem_req_ready_i) begin
                valid_reg <= 1'b0;
            end
            ids_free_reg <= ids_free_reg + CW'(rel_ok) - CW'(grant);
        end
    end

    assign mem_req_valid_o = valid_reg;
    assign mem_req_o       = req_reg;
    assign mem_req_id_o    = id_reg;
    assign ids_free_o      = ids_free_reg;
    assign rel_err_o       = rel_err_reg;

endmodule
